m10k_row_transpose_ctrl: RTL

//  Controller that sits directly on the ports of the 2*M-row M10K row memory.
//  On i_start it reads an MxN block of DATA_LEN-bit words row by row and captures it in a register buffer.
//  It then writes the transposed block back as N rows, so a downstream stage can fetch matrix columns as single rows.
//  It drives the memory's read address, write address, write data and write enable, and consumes its read data.

---
 rtl/m10k_row_transpose_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/m10k_row_transpose_ctrl.sv
// m10k_row_transpose_ctrl
// Reads an MxN block from the M10K row memory one row per cycle into a
// register buffer. It then writes the transposed block back as N rows, so
// each destination row holds one column of the source block.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start
// READ  | issuing source row addresses SRC_BASE..SRC_BASE+M-1
// DRAIN | capturing the last row, preloading first transposed row
// WRITE | writing transposed rows DST_BASE..DST_BASE+N-1 (o_wr_en=1)
// DONE  | one-cycle o_done pulse
module m10k_row_transpose_ctrl #(
  parameter int DATA_LEN     = 32,
  parameter int M            = 8,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int SRC_BASE     = 0,
  parameter int DST_BASE     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ADDRESS_SIZE-1:0] o_read_address,
  input  logic [DATA_LEN*N-1:0]   i_read_data,
  output logic [ADDRESS_SIZE-1:0] o_write_address,
  output logic [DATA_LEN*N-1:0]   o_write_data,
  output logic                    o_wr_en
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDRESS_SIZE-1:0] SRC_A = ADDRESS_SIZE'(SRC_BASE);
  localparam logic [ADDRESS_SIZE-1:0] DST_A = ADDRESS_SIZE'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q;
  logic [RW-1:0]           r_q;
  logic [CW-1:0]           c_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    wr_en_q;
  logic [ADDRESS_SIZE-1:0] rd_addr_q;
  logic [ADDRESS_SIZE-1:0] wr_addr_q;
  logic [DATA_LEN*N-1:0]   wr_data_q;

  // Capture buffer: one source row per entry, deliberately not reset.
  logic [DATA_LEN*N-1:0]   row_buf_q [M];

  logic [DATA_LEN*N-1:0]   row_eff   [M];
  logic [CW-1:0]           col_sel_d;
  logic [DATA_LEN*N-1:0]   wr_data_d;

  // Next transposed row. In DRAIN the last source row is still on
  // i_read_data, so it is taken directly from the memory port.
  always_comb begin
    for (int k = 0; k < M; k++) begin
      row_eff[k] = row_buf_q[k];
    end
    if (state_q == S_DRAIN) begin
      row_eff[M-1] = i_read_data;
    end
    col_sel_d = (state_q == S_DRAIN) ? '0 : c_q + CW'(1);
    wr_data_d = '0;
    for (int k = 0; k < M; k++) begin
      wr_data_d[k*DATA_LEN +: DATA_LEN] = row_eff[k][col_sel_d*DATA_LEN +: DATA_LEN];
    end
  end

  // Row capture: data for the address issued last cycle arrives now.
  always_ff @(posedge i_clk) begin
    if (state_q == S_READ && r_q != '0) begin
      row_buf_q[r_q - RW'(1)] <= i_read_data;
    end else if (state_q == S_DRAIN) begin
      row_buf_q[M-1] <= i_read_data;
    end
  end

  // Sequencing FSM with registered memory-side outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q   <= S_READ;
            busy_q    <= 1'b1;
            r_q       <= '0;
            rd_addr_q <= SRC_A;
          end
        end
        S_READ: begin
          if (r_q == RW'(M-1)) begin
            state_q <= S_DRAIN;
          end else begin
            r_q       <= r_q + RW'(1);
            rd_addr_q <= rd_addr_q + ADDRESS_SIZE'(1);
          end
        end
        S_DRAIN: begin
          state_q   <= S_WRITE;
          c_q       <= '0;
          wr_en_q   <= 1'b1;
          wr_addr_q <= DST_A;
          wr_data_q <= wr_data_d;
        end
        S_WRITE: begin
          if (c_q == CW'(N-1)) begin
            state_q <= S_DONE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            c_q       <= c_q + CW'(1);
            wr_addr_q <= wr_addr_q + ADDRESS_SIZE'(1);
            wr_data_q <= wr_data_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_wr_en         = wr_en_q;
  assign o_read_address  = rd_addr_q;
  assign o_write_address = wr_addr_q;
  assign o_write_data    = wr_data_q;

endmodule
